// File: rtl/matmul_pkg.sv
// matmul_pkg: shared constants and state encoding for the matmul loader/engine slice
package matmul_pkg;
   localparam int DIM    = 4;
   localparam int ELEM_W = 8;
   localparam logic [9:0] DEF_BASE_A = 10'h000;
   localparam logic [9:0] DEF_BASE_B = 10'h100;
   localparam logic [9:0] DEF_BASE_C = 10'h200;
   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      LOAD_A  = 4'd1,
      LOAD_B  = 4'd2,
      WRITE_B = 4'd3,
      KICK    = 4'd4,
      WAIT_LO = 4'd5,
      WAIT_HI = 4'd6
   } state_t;
endpackage

// File: rtl/matmul_b_transpose.sv
// matmul_b_transpose: 4x4 byte store written row-major, read as packed columns
module matmul_b_transpose
   import matmul_pkg::*;
(
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    we,
   input  logic [1:0]              wr_row,
   input  logic [1:0]              wr_col,
   input  logic [ELEM_W-1:0]       wr_data,
   input  logic [1:0]              rd_col,
   output logic [DIM*ELEM_W-1:0]   rd_data
);
   logic [ELEM_W-1:0] m [DIM][DIM];
   // byte writes at (row, col); the whole array clears on reset
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
               m[r][c] <= '0;
      end else if (we) begin
         m[wr_row][wr_col] <= wr_data;
      end
   end
   for (genvar g = 0; g < DIM; g++) begin : g_col
      assign rd_data[g*ELEM_W +: ELEM_W] = m[g][rd_col];
   end
endmodule

// File: rtl/matmul_loader.sv
// matmul_loader: packs a byte stream of A and B into operand memory, then kicks the engine
module matmul_loader
   import matmul_pkg::*;
#(
   parameter logic [9:0] BASE_A = DEF_BASE_A,
   parameter logic [9:0] BASE_B = DEF_BASE_B
)(
   input  logic        clk,
   input  logic        rstn,
   input  logic        load_start,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [7:0]  s_data,
   input  logic        s_last,
   output logic        mem_en_write,
   output logic [9:0]  mem_addr,
   output logic [31:0] mem_data,
   output logic        kick_start,
   input  logic        mm_ready,
   output logic        busy,
   output logic        done,
   output logic        err
);
   state_t      state, nxt;
   logic [3:0]  k;
   logic [23:0] a_pack;
   logic        acc, ferr, wr_a, wr_b;
   logic [1:0]  rd_col;
   logic [31:0] col;

   assign acc    = s_valid && s_ready;
   assign ferr   = acc && (s_last != (state == LOAD_B && k == 4'd15));
   assign wr_a   = state == LOAD_A && acc && !ferr && k[1:0] == 2'd3;
   assign wr_b   = (state == LOAD_B && acc && !ferr && k == 4'd15) || (state == WRITE_B && k[1:0] != 2'd3);
   assign rd_col = state == WRITE_B ? k[1:0] + 2'd1 : 2'd0;

   matmul_b_transpose u_bt (
      .clk     (clk),
      .rstn    (rstn),
      .we      (state == LOAD_B && acc && !ferr),
      .wr_row  (k[3:2]),
      .wr_col  (k[1:0]),
      .wr_data (s_data),
      .rd_col  (rd_col),
      .rd_data (col)
   );

   // next-state: a framing error in either load phase returns straight to IDLE
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = load_start ? LOAD_A : IDLE;
         LOAD_A:  nxt = ferr ? IDLE : (acc && k == 4'd15) ? LOAD_B : LOAD_A;
         LOAD_B:  nxt = ferr ? IDLE : (acc && k == 4'd15) ? WRITE_B : LOAD_B;
         WRITE_B: nxt = k[1:0] == 2'd3 ? KICK : WRITE_B;
         KICK:    nxt = mm_ready ? WAIT_LO : KICK;
         WAIT_LO: nxt = mm_ready ? WAIT_LO : WAIT_HI;
         WAIT_HI: nxt = mm_ready ? IDLE : WAIT_HI;
         default: nxt = IDLE;
      endcase
   end

   // state, counters and registered outputs; A row bytes shift in low-lane first
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state        <= IDLE;
         k            <= '0;
         a_pack       <= '0;
         s_ready      <= 1'b0;
         busy         <= 1'b0;
         mem_en_write <= 1'b0;
         mem_addr     <= '0;
         mem_data     <= '0;
         kick_start   <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
      end else begin
         state        <= nxt;
         k            <= state == IDLE ? 4'd0 : (state == WRITE_B || (acc && !ferr)) ? k + 4'd1 : k;
         a_pack       <= acc ? {s_data, a_pack[23:8]} : a_pack;
         s_ready      <= nxt == LOAD_A || nxt == LOAD_B;
         busy         <= nxt != IDLE;
         mem_en_write <= wr_a || wr_b;
         mem_addr     <= wr_a ? BASE_A + {8'd0, k[3:2]} : wr_b ? BASE_B + {8'd0, rd_col} : 10'd0;
         mem_data     <= wr_a ? {s_data, a_pack} : wr_b ? col : 32'd0;
         kick_start   <= state == KICK && mm_ready;
         done         <= state == WAIT_HI && mm_ready;
         err          <= ferr;
      end
   end
endmodule

// File: tb/tb_matmul_loader.sv
// tb_matmul_loader: directed table-driven checks of the matmul loader
module tb_matmul_loader;
   import matmul_pkg::*;

   logic        clk = 0, rstn = 0, load_start = 0, s_valid = 0, s_last = 0, mm_ready = 1;
   logic [7:0]  s_data = 0;
   logic        s_ready, mem_en_write, kick_start, busy, done, err;
   logic [9:0]  mem_addr;
   logic [31:0] mem_data;

   always #5 clk = ~clk;

   matmul_loader dut (
      .clk(clk), .rstn(rstn), .load_start(load_start), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .s_last(s_last), .mem_en_write(mem_en_write), .mem_addr(mem_addr),
      .mem_data(mem_data), .kick_start(kick_start), .mm_ready(mm_ready), .busy(busy),
      .done(done), .err(err)
   );

   typedef struct {int cyc; logic [9:0] addr; logic [31:0] data;} wr_t;
   typedef struct {string name; logic [9:0] addr; logic [31:0] exp;} vec_t;

   int   checks = 0, errors = 0, cyc = 0;
   int   eng_lat = 3, eng_busy = 0;
   bit   hold_lo = 0;
   wr_t  wlog[$];
   int   kick_q[$], done_q[$], err_q[$], rise_q[$];
   int   acc_cyc[33];
   logic [7:0]  a_m[16], b_m[16];
   logic [31:0] mem[1024];
   vec_t tbl[12];

   always @(posedge clk) cyc <= cyc + 1;

   // output monitor plus a simple engine: ready drops on kick and returns eng_lat cycles later
   always @(negedge clk) begin
      if (mem_en_write) wlog.push_back('{cyc, mem_addr, mem_data});
      if (kick_start) kick_q.push_back(cyc);
      if (done) done_q.push_back(cyc);
      if (err) err_q.push_back(cyc);
      if (kick_start) eng_busy = eng_lat;
      else if (eng_busy > 0) eng_busy--;
      if (!mm_ready && eng_busy == 0 && !hold_lo) rise_q.push_back(cyc);
      mm_ready = eng_busy == 0 && !hold_lo;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic start_job();
      load_start = 1;
      @(posedge clk); #1;
      load_start = 0;
   endtask

   task automatic send(input int n, input int last_at, input int gap);
      for (int i = 0; i < n; i++) begin
         bit got = 0;
         s_data = i < 16 ? a_m[i] : b_m[i-16];
         s_last = (i == last_at);
         for (int t = 0; t < 100 && !got; t++) begin
            s_valid = ($urandom_range(99) >= gap);
            @(negedge clk);
            if (s_valid && s_ready) begin
               got = 1;
               acc_cyc[i+1] = cyc;
            end
            @(posedge clk); #1;
         end
         chk("byte_accepted", {31'd0, got}, 1);
      end
      s_valid = 0;
      s_last = 0;
   endtask

   task automatic run_job(input int gap);
      int w0 = wlog.size(), k0 = kick_q.size(), d0 = done_q.size(), e0 = err_q.size();
      foreach (mem[i]) mem[i] = 32'hDEADBEEF;
      start_job();
      send(32, 31, gap);
      for (int t = 0; t < 300 && done_q.size() == d0; t++) @(posedge clk);
      #1;
      chk("job_done", done_q.size() - d0, 1);
      chk("job_writes", wlog.size() - w0, 8);
      chk("job_kicks", kick_q.size() - k0, 1);
      chk("job_errs", err_q.size() - e0, 0);
      chk("job_busy_after", {31'd0, busy}, 0);
      for (int j = 0; j < 8 && w0 + j < wlog.size(); j++) begin
         chk("wr_cycle", wlog[w0+j].cyc, j < 4 ? acc_cyc[4*j+4] + 1 : acc_cyc[32] + j - 3);
         mem[wlog[w0+j].addr] = wlog[w0+j].data;
      end
   endtask

   task automatic check_tbl(input int lo, input int hi);
      for (int i = lo; i < hi; i++) chk(tbl[i].name, mem[tbl[i].addr], tbl[i].exp);
   endtask

   initial begin
      int w0, k0, d0, e0, r0;
      tbl[0]  = '{"a_row0", 10'h000, 32'h04030201};
      tbl[1]  = '{"a_row1", 10'h001, 32'h08070605};
      tbl[2]  = '{"a_row2", 10'h002, 32'h0C0B0A09};
      tbl[3]  = '{"a_row3", 10'h003, 32'h100F0E0D};
      tbl[4]  = '{"b_col0_id", 10'h100, 32'h00000001};
      tbl[5]  = '{"b_col1_id", 10'h101, 32'h00000100};
      tbl[6]  = '{"b_col2_id", 10'h102, 32'h00010000};
      tbl[7]  = '{"b_col3_id", 10'h103, 32'h01000000};
      tbl[8]  = '{"b_col0_hex", 10'h100, 32'h41312111};
      tbl[9]  = '{"b_col1_hex", 10'h101, 32'h42322212};
      tbl[10] = '{"b_col2_hex", 10'h102, 32'h43332313};
      tbl[11] = '{"b_col3_hex", 10'h103, 32'h44342414};
      for (int i = 0; i < 16; i++) begin
         a_m[i] = 8'(i + 1);
         b_m[i] = (i / 4 == i % 4) ? 8'd1 : 8'd0;
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ctrl", 32'({s_ready, mem_en_write, kick_start, busy, done, err}), 0);
      chk("rst_addr", {22'd0, mem_addr}, 0);
      chk("rst_data", mem_data, 0);
      @(posedge clk); #1;
      rstn = 1;
      repeat (2) @(posedge clk); #1;
      chk("idle_busy", {31'd0, busy}, 0);

      run_job(0);
      check_tbl(0, 8);

      for (int i = 0; i < 16; i++) b_m[i] = 8'(((i / 4 + 1) << 4) | (i % 4 + 1));
      run_job(0);
      check_tbl(8, 12);

      for (int i = 0; i < 16; i++) b_m[i] = (i / 4 == i % 4) ? 8'd1 : 8'd0;
      run_job(50);
      check_tbl(0, 8);

      w0 = wlog.size(); k0 = kick_q.size(); e0 = err_q.size();
      start_job();
      send(20, 19, 0);
      repeat (3) @(posedge clk); #1;
      chk("ferr_count", err_q.size() - e0, 1);
      if (err_q.size() > e0) chk("ferr_cycle", err_q[e0], acc_cyc[20] + 1);
      chk("ferr_busy", {31'd0, busy}, 0);
      repeat (20) @(posedge clk); #1;
      chk("ferr_writes", wlog.size() - w0, 4);
      chk("ferr_kicks", kick_q.size() - k0, 0);
      run_job(0);
      check_tbl(0, 8);

      eng_lat = 30;
      hold_lo = 1;
      k0 = kick_q.size(); d0 = done_q.size();
      start_job();
      send(32, 31, 0);
      repeat (14) @(posedge clk); #1;
      chk("hold_no_kick", kick_q.size() - k0, 0);
      r0 = rise_q.size();
      hold_lo = 0;
      for (int t = 0; t < 20 && kick_q.size() == k0; t++) @(posedge clk);
      #1;
      chk("hold_kick", kick_q.size() - k0, 1);
      if (kick_q.size() > k0 && rise_q.size() > r0) chk("hold_kick_cycle", kick_q[k0], rise_q[r0] + 1);
      for (int t = 0; t < 100 && done_q.size() == d0; t++) @(posedge clk);
      repeat (5) @(posedge clk); #1;
      chk("hold_done", done_q.size() - d0, 1);
      chk("hold_rises", rise_q.size() - r0, 2);
      if (done_q.size() > d0 && rise_q.size() > r0 + 1) chk("hold_done_cycle", done_q[d0], rise_q[r0+1] + 1);
      eng_lat = 3;

      start_job();
      send(10, -1, 0);
      w0 = wlog.size(); k0 = kick_q.size();
      rstn = 0;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_ctrl", 32'({s_ready, mem_en_write, kick_start, busy, done, err}), 0);
      chk("midrst_addr", {22'd0, mem_addr}, 0);
      chk("midrst_data", mem_data, 0);
      @(posedge clk); #1;
      rstn = 1;
      repeat (50) @(posedge clk); #1;
      chk("midrst_writes", wlog.size() - w0, 0);
      chk("midrst_kicks", kick_q.size() - k0, 0);
      chk("midrst_busy", {31'd0, busy}, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/matmul_loader.md
Name: matmul_loader

Overview:
- Upstream stage of the 4x4 matmul/pooling engine.
- Accepts a byte-serial stream of matrix A (row-major) followed by matrix B (row-major).
- Packs A into row words and transposes B into column words. Writes both into the shared operand memory the engine reads: A rows at BASE_A+r, B columns at BASE_B+c.
- Then issues a single-cycle kick_start to the engine and reports completion when the engine returns to ready.

Parameters:
- BASE_A, 10'h000, word address of A row 0 (rows at BASE_A..BASE_A+3)
- BASE_B, 10'h100, word address of B column 0 (columns at BASE_B..BASE_B+3)

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- load_start  in  1  begin a load/compute job; sampled in IDLE only
- s_valid  in  1  stream byte valid
- s_ready  out  1  stream byte accepted when s_valid&&s_ready
- s_data  in  8  unsigned matrix element
- s_last  in  1  must be high exactly on the 32nd byte (B[3][3])
- mem_en_write  out  1  operand memory write strobe
- mem_addr  out  10  operand memory word address
- mem_data  out  32  packed word; element k at bits [8k+7:8k]
- kick_start  out  1  one-cycle start pulse to the matmul engine
- mm_ready  in  1  engine ready/idle flag
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the engine finishes the job
- err  out  1  one-cycle pulse on a framing error (job aborted)

Behaviour:
- Reset (rstn=0 at clk edge):
  - Outputs: s_ready, mem_en_write, kick_start, busy, done and err are all 0; mem_addr and mem_data are 0.
  - Internals: state=IDLE; counters and B buffer cleared.
  - A reset mid-job abandons it with no further writes or kick.
- States:
  - IDLE: busy=0. load_start=1 -> LOAD_A.
  - LOAD_A: s_ready=1. 4-bit element counter k (0..15). Byte k goes to lane k[1:0] of the row k[3:2] packing register.
    - On acceptance of a byte with k[1:0]=3, the next cycle drives mem_en_write=1, mem_addr=BASE_A+k[3:2], mem_data=packed row.
    - After byte 15 is accepted -> LOAD_B, with k reset to 0. s_ready stays 1, so LOAD_B may accept a byte in the same cycle as the final A write.
  - LOAD_B: s_ready=1. Byte k is stored in b_buf[k[3:2]][k[1:0]] (row r, column c). After byte 15 is accepted -> WRITE_B.
  - WRITE_B: s_ready=0. Four consecutive cycles, c=0..3.
    - Each cycle drives mem_en_write=1, mem_addr=BASE_B+c, mem_data={b[3][c],b[2][c],b[1][c],b[0][c]}.
    - The first write occurs in the cycle after the 32nd byte is accepted. Then -> KICK.
  - KICK: wait for mm_ready=1. In the cycle mm_ready=1 is seen, drive kick_start=1 for exactly one cycle, then -> WAIT_LO.
  - WAIT_LO: wait for mm_ready=0 (engine has started). -> WAIT_HI.
  - WAIT_HI: wait for mm_ready=1, then pulse done=1 for one cycle and -> IDLE.
- Framing rules:
  - s_last=1 on any accepted byte other than the 32nd: err pulses the next cycle. No further writes, no kick, state -> IDLE.
  - s_last=0 on the 32nd byte: same error response.
  - A writes that already completed remain in memory.
- load_start while busy=1 is ignored.
- s_valid=0 stalls the counters; no timeout.
- All outputs are registered; mem_en_write is never high in IDLE, KICK, WAIT_LO or WAIT_HI.
- Arithmetic: elements are unsigned 8-bit, with no modification or saturation. Addresses are computed as 10-bit sums with no wrap checks; BASE+3 must fit in 10 bits.
- Minimum job latency, from load_start to kick_start with continuous s_valid and mm_ready=1: 1 + 32 + 4 + 1 cycles.

Decomposition:
- Shared package matmul_pkg:
  - state encoding constants (4-bit, IDLE..WAIT_HI)
  - DIM=4 and ELEM_W=8
  - default BASE_A=10'h000, BASE_B=10'h100, BASE_C=10'h200, for reuse by the engine and the bench
- One natural sub-module: matmul_b_transpose, a 4x4 byte register file with a row-major write port and a column-packed 32-bit read port. The rest stays in matmul_loader.

Test Plan:
- A=1..16 and B=identity, continuous valid, mm_ready=1:
  - A writes: 0x000=0x04030201, 0x001=0x08070605, 0x002=0x0C0B0A09, 0x003=0x100F0E0D.
  - B writes: 0x100=0x00000001, 0x101=0x00000100, 0x102=0x00010000, 0x103=0x01000000.
  - Then one kick_start.
- B row-major 0x11..0x44 (B[r][c]=0x(r+1)(c+1)): column 2 write at 0x102 = 0x43332313.
- Random s_valid gaps (~50%): same memory contents as the first scenario. Writes occur only on the cycle after each 4th/16th accepted byte.
- s_last asserted on byte 20: err pulse the next cycle, no B writes, no kick_start, busy=0, and a subsequent clean job succeeds.
- mm_ready held 0 for 10 cycles after WRITE_B: kick_start is delayed until mm_ready=1. Then the model drops ready for 30 cycles and restores it, and done pulses once, 1 cycle after ready returns.
- rstn=0 asserted after byte 10: the next edge clears all outputs, and no mem_en_write or kick_start appears afterwards.
